// File: rtl/mpi_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mpi_bus_master
// Description : Initiator for the BK0010 multiplexed active-low MPI bus:
//               address/SYNC, DIN/DOUT data phase, RPLY handshake, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mpi_bus_master #(
    parameter int T_ADDR  = 1,
    parameter int T_HOLD  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        pin_sync_n,
    output logic        pin_din_n,
    output logic        pin_dout_n,
    input  logic        pin_rply_n,
    inout  wire  [15:0] pin_ad_n
);

    localparam int c_cnt_max = (TIMEOUT > T_ADDR)
                             ? ((TIMEOUT > T_HOLD) ? TIMEOUT : T_HOLD)
                             : ((T_ADDR > T_HOLD) ? T_ADDR : T_HOLD);
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(T_ADDR - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(T_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_timeout   = c_cnt_w'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_SYNC    = 3'd2,
        S_DATA    = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_we;
    logic [15:0]          r_wdata;
    logic [15:0]          r_ad_out;
    logic                 r_ad_oe;
    logic                 r_sync_n;
    logic                 r_din_n;
    logic                 r_dout_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [15:0]          r_rdata;
    logic                 r_rply_meta;
    logic                 r_rply_s;

    // Outputs are updated on the transition into each state, so every bus
    // pin comes straight from a flop.
    always_ff @(posedge pin_clk) begin
        if (!pin_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_ad_out    <= '0;
            r_ad_oe     <= 1'b0;
            r_sync_n    <= 1'b1;
            r_din_n     <= 1'b1;
            r_dout_n    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_rply_meta <= 1'b1;
            r_rply_s    <= 1'b1;
        end else begin
            r_rply_meta <= pin_rply_n;
            r_rply_s    <= r_rply_meta;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state  <= S_ADDR;
                        r_cnt    <= '0;
                        r_we     <= we;
                        r_wdata  <= wdata;
                        r_ad_out <= ~addr;
                        r_ad_oe  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_err    <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (r_cnt == c_addr_last) begin
                        r_state  <= S_SYNC;
                        r_cnt    <= '0;
                        r_sync_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SYNC: begin
                    if (r_cnt == c_hold_last) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        if (r_we) begin
                            r_ad_out <= ~r_wdata;
                            r_dout_n <= 1'b0;
                        end else begin
                            // Address released in the same cycle DIN asserts
                            r_ad_oe <= 1'b0;
                            r_din_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (!r_rply_s) begin
                        if (!r_we) begin
                            r_rdata <= ~pin_ad_n;
                        end
                        r_state  <= S_RELEASE;
                        r_cnt    <= '0;
                        r_din_n  <= 1'b1;
                        r_dout_n <= 1'b1;
                        r_ad_oe  <= 1'b0;
                    end else if (r_cnt == c_timeout) begin
                        r_state  <= S_DONE;
                        r_sync_n <= 1'b1;
                        r_din_n  <= 1'b1;
                        r_dout_n <= 1'b1;
                        r_ad_oe  <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (r_rply_s || (r_cnt == c_timeout)) begin
                        r_state  <= S_DONE;
                        r_sync_n <= 1'b1;
                        r_done   <= 1'b1;
                        r_err    <= !r_rply_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pin_ad_n   = r_ad_oe ? r_ad_out : 16'hzzzz;
    assign pin_sync_n = r_sync_n;
    assign pin_din_n  = r_din_n;
    assign pin_dout_n = r_dout_n;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;

endmodule
`default_nettype wire
